// File: rtl/wb_decode_mux_pkg.sv
// Shared types and constants for the Wishbone I/O decoder/multiplexer.
package wb_decode_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic {
        CAUSE_UNMAPPED = 1'b0,
        CAUSE_TIMEOUT  = 1'b1
    } err_cause_e;

    function automatic logic addr_match(input logic [31:0] adr,
                                        input logic [31:0] base,
                                        input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/wb_decode_mux_if.sv
// Single Wishbone B4 master-side bus bundle with master/slave views.
interface wb_decode_mux_if #(
    parameter int DW = 32
);
    logic [31:0]     adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic            we;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic [DW-1:0]   dat_r;
    logic            ack;
    logic            err;
    logic            rty;

    modport master (
        output adr, dat_w, sel, we, cyc, stb, cti, bte,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  adr, dat_w, sel, we, cyc, stb, cti, bte,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/wb_decode_mux_addr_decode.sv
// Combinational address decoder: lowest matching slave index wins.
module wb_addr_decode
    import wb_decode_mux_pkg::*;
#(
    parameter int                          NUM_SLAVES = 8,
    parameter logic [NUM_SLAVES*32-1:0]    MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*32-1:0]    MATCH_MASK = '0
) (
    input  logic [31:0]           adr_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic                  hit_o
);

    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!hit_o && addr_match(adr_i, MATCH_ADDR[32*i +: 32], MATCH_MASK[32*i +: 32])) begin
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_decode_mux.sv
// Wishbone single-master, N-slave decoder/mux with bus error and access watchdog.
// Optional error statistics ports: define WB_DECODE_MUX_STATS_EN.
//   state  | meaning
//   IDLE   | no access; decode on cyc&stb
//   ACTIVE | selected slave owns the cycle until cyc falls
//   ERR    | one-cycle error response (unmapped or timeout)
module wb_decode_mux
    import wb_decode_mux_pkg::*;
#(
    parameter int                          NUM_SLAVES = 8,
    parameter int                          DW         = 32,
    parameter logic [NUM_SLAVES*32-1:0]    MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*32-1:0]    MATCH_MASK = '0,
    parameter int unsigned                 TIMEOUT    = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,

    input  logic [31:0]                  wbm_adr_i,
    input  logic [DW-1:0]                wbm_dat_i,
    input  logic [DW/8-1:0]              wbm_sel_i,
    input  logic                         wbm_we_i,
    input  logic                         wbm_cyc_i,
    input  logic                         wbm_stb_i,
    input  logic [2:0]                   wbm_cti_i,
    input  logic [1:0]                   wbm_bte_i,
    output logic [DW-1:0]                wbm_dat_o,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    output logic                         wbm_rty_o,

    output logic [NUM_SLAVES*32-1:0]     wbs_adr_o,
    output logic [NUM_SLAVES*DW-1:0]     wbs_dat_o,
    output logic [NUM_SLAVES*DW/8-1:0]   wbs_sel_o,
    output logic [NUM_SLAVES-1:0]        wbs_we_o,
    output logic [NUM_SLAVES*3-1:0]      wbs_cti_o,
    output logic [NUM_SLAVES*2-1:0]      wbs_bte_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    input  logic [NUM_SLAVES*DW-1:0]     wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]        wbs_err_i,
    input  logic [NUM_SLAVES-1:0]        wbs_rty_i
`ifdef WB_DECODE_MUX_STATS_EN
   ,output logic [15:0]                  err_count_o,
    output logic [31:0]                  last_err_adr_o,
    output logic                         last_err_cause_o
`endif
);

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

    state_e                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [15:0]             cnt_q, cnt_d;

    logic [NUM_SLAVES-1:0]   dec_sel;
    logic                    dec_hit;
    logic                    rsp_ack, rsp_err, rsp_rty, rsp_any;
    logic [DW-1:0]           rsp_dat;
    logic                    at_limit;

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .MATCH_ADDR (MATCH_ADDR),
        .MATCH_MASK (MATCH_MASK)
    ) u_addr_decode (
        .adr_i (wbm_adr_i),
        .sel_o (dec_sel),
        .hit_o (dec_hit)
    );

    assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
    assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
    assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
    assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
    assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
    assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

    // Responses from unselected slaves are masked out here.
    assign rsp_ack  = |(wbs_ack_i & sel_q);
    assign rsp_err  = |(wbs_err_i & sel_q);
    assign rsp_rty  = |(wbs_rty_i & sel_q);
    assign rsp_any  = rsp_ack | rsp_err | rsp_rty;
    assign at_limit = (state_q == ACTIVE) && (cnt_q == TO_LIMIT);

    always_comb begin
        rsp_dat = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                rsp_dat |= wbs_dat_i[DW*i +: DW];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wbm_cyc_i && wbm_stb_i) begin
                    sel_d   = dec_sel;
                    state_d = dec_hit ? ACTIVE : ERR;
                end
            end
            ACTIVE: begin
                if (!wbm_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (rsp_any) begin
                    cnt_d = '0;
                end else if (at_limit) begin
                    state_d = ERR;
                    cnt_d   = '0;
                end else if (wbm_stb_i) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ERR: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are withdrawn in the cycle the watchdog expires.
    always_comb begin
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        wbm_dat_o = '0;
        wbm_ack_o = 1'b0;
        wbm_err_o = 1'b0;
        wbm_rty_o = 1'b0;
        unique case (state_q)
            ACTIVE: begin
                if (!at_limit) begin
                    wbs_cyc_o = wbm_cyc_i ? sel_q : '0;
                    wbs_stb_o = (wbm_cyc_i && wbm_stb_i) ? sel_q : '0;
                end
                wbm_dat_o = rsp_dat;
                wbm_ack_o = rsp_ack;
                wbm_err_o = rsp_err;
                wbm_rty_o = rsp_rty;
            end
            ERR: begin
                wbm_err_o = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef WB_DECODE_MUX_STATS_EN
    logic [15:0] err_count_q;
    logic [31:0] last_err_adr_q;
    err_cause_e  last_err_cause_q;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            err_count_q      <= '0;
            last_err_adr_q   <= '0;
            last_err_cause_q <= CAUSE_UNMAPPED;
        end else if (state_d == ERR && state_q != ERR) begin
            if (err_count_q != 16'hffff) begin
                err_count_q <= err_count_q + 16'd1;
            end
            last_err_adr_q   <= wbm_adr_i;
            last_err_cause_q <= (state_q == IDLE) ? CAUSE_UNMAPPED : CAUSE_TIMEOUT;
        end
    end

    assign err_count_o      = err_count_q;
    assign last_err_adr_o   = last_err_adr_q;
    assign last_err_cause_o = last_err_cause_q;
`endif

endmodule

// File: tb/tb_wb_decode_mux.sv
// Directed bench for wb_decode_mux: 3 slaves, TIMEOUT=16.
module tb_wb_decode_mux;
    import wb_decode_mux_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_decode_mux_if #(.DW(DW)) bus();

    logic [N*32-1:0]   wbs_adr_o;
    logic [N*DW-1:0]   wbs_dat_o;
    logic [N*DW/8-1:0] wbs_sel_o;
    logic [N-1:0]      wbs_we_o;
    logic [N*3-1:0]    wbs_cti_o;
    logic [N*2-1:0]    wbs_bte_o;
    logic [N-1:0]      wbs_cyc_o;
    logic [N-1:0]      wbs_stb_o;
    logic [N*DW-1:0]   wbs_dat_i;
    logic [N-1:0]      wbs_ack_i;
    logic [N-1:0]      wbs_err_i;
    logic [N-1:0]      wbs_rty_i;

    logic [N-1:0] zw_en     = '0;
    logic [N-1:0] force_ack = '0;
    logic [N-1:0] force_err = '0;
    logic [N-1:0] force_rty = '0;

    assign wbs_dat_i = {32'hA5A5A5A5, 32'h22222222, 32'h11111111};
    assign wbs_ack_i = (wbs_stb_o & zw_en) | force_ack;
    assign wbs_err_i = force_err;
    assign wbs_rty_i = force_rty;

`ifdef WB_DECODE_MUX_STATS_EN
    logic [15:0] err_count;
    logic [31:0] last_err_adr;
    logic        last_err_cause;
`endif

    wb_decode_mux #(
        .NUM_SLAVES (N),
        .DW         (DW),
        .MATCH_ADDR ({32'h00001040, 32'h00001000, 32'h00000000}),
        .MATCH_MASK ({32'hffffffc0, 32'hffffffc0, 32'hfffff000}),
        .TIMEOUT    (16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wbm_adr_i  (bus.adr),
        .wbm_dat_i  (bus.dat_w),
        .wbm_sel_i  (bus.sel),
        .wbm_we_i   (bus.we),
        .wbm_cyc_i  (bus.cyc),
        .wbm_stb_i  (bus.stb),
        .wbm_cti_i  (bus.cti),
        .wbm_bte_i  (bus.bte),
        .wbm_dat_o  (bus.dat_r),
        .wbm_ack_o  (bus.ack),
        .wbm_err_o  (bus.err),
        .wbm_rty_o  (bus.rty),
        .wbs_adr_o  (wbs_adr_o),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_sel_o  (wbs_sel_o),
        .wbs_we_o   (wbs_we_o),
        .wbs_cti_o  (wbs_cti_o),
        .wbs_bte_o  (wbs_bte_o),
        .wbs_cyc_o  (wbs_cyc_o),
        .wbs_stb_o  (wbs_stb_o),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_i  (wbs_ack_i),
        .wbs_err_i  (wbs_err_i),
        .wbs_rty_i  (wbs_rty_i)
`ifdef WB_DECODE_MUX_STATS_EN
       ,.err_count_o      (err_count),
        .last_err_adr_o   (last_err_adr),
        .last_err_cause_o (last_err_cause)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] adr, input logic we, input logic [2:0] cti);
        bus.adr = adr;
        bus.we  = we;
        bus.cti = cti;
        bus.cyc = 1'b1;
        bus.stb = 1'b1;
    endtask

    task automatic idle_bus();
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.cti = CTI_CLASSIC;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.adr   = '0;
        bus.dat_w = 32'hDEADBEEF;
        bus.sel   = 4'hF;
        bus.we    = 1'b0;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.cti   = CTI_CLASSIC;
        bus.bte   = BTE_LINEAR;
        rst_n     = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Reset state and response gating in IDLE
        force_ack = 3'b111;
        force_err = 3'b111;
        sample();
        chk("rst_cyc", 64'(wbs_cyc_o), 64'h0);
        chk("rst_ack", 64'(bus.ack), 64'h0);
        chk("rst_err", 64'(bus.err), 64'h0);
        chk("rst_dat", 64'(bus.dat_r), 64'h0);
`ifdef WB_DECODE_MUX_STATS_EN
        chk("rst_errcnt", 64'(err_count), 64'h0);
`endif
        step();
        force_ack = '0;
        force_err = '0;

        // Read slave2 zero-wait; err from unselected slave0 is ignored
        zw_en     = 3'b100;
        force_err = 3'b001;
        req(32'h00001044, 1'b0, CTI_CLASSIC);
        sample();
        chk("rd2_c0_stb", 64'(wbs_stb_o), 64'h0);
        chk("rd2_c0_ack", 64'(bus.ack), 64'h0);
        step();
        sample();
        chk("rd2_c1_stb", 64'(wbs_stb_o), 64'h4);
        chk("rd2_c1_ack", 64'(bus.ack), 64'h1);
        chk("rd2_c1_dat", 64'(bus.dat_r), 64'hA5A5A5A5);
        chk("rd2_c1_err", 64'(bus.err), 64'h0);
        step();
        idle_bus();
        force_err = '0;
        sample();
        chk("rd2_c2_cyc", 64'(wbs_cyc_o), 64'h0);
        step();

        // Unmapped write
        zw_en = 3'b111;
        req(32'h00002000, 1'b1, CTI_CLASSIC);
        sample();
        chk("unm_c0_err", 64'(bus.err), 64'h0);
        step();
        sample();
        chk("unm_c1_err", 64'(bus.err), 64'h1);
        chk("unm_c1_stb", 64'(wbs_stb_o), 64'h0);
        chk("unm_c1_dat", 64'(bus.dat_r), 64'h0);
        step();
        idle_bus();
        sample();
        chk("unm_c2_err", 64'(bus.err), 64'h0);
`ifdef WB_DECODE_MUX_STATS_EN
        chk("unm_errcnt", 64'(err_count), 64'h1);
        chk("unm_erradr", 64'(last_err_adr), 64'h00002000);
        chk("unm_cause", 64'(last_err_cause), 64'h0);
`endif
        step();

        // Timeout on slave1
        zw_en = 3'b000;
        req(32'h00001000, 1'b0, CTI_CLASSIC);
        sample();
        step();
        sample();
        chk("to_c1_stb", 64'(wbs_stb_o), 64'h2);
        repeat (15) step();
        sample();
        chk("to_c16_stb", 64'(wbs_stb_o), 64'h2);
        chk("to_c16_err", 64'(bus.err), 64'h0);
        step();
        sample();
        chk("to_c17_stb", 64'(wbs_stb_o), 64'h0);
        chk("to_c17_cyc", 64'(wbs_cyc_o), 64'h0);
        chk("to_c17_err", 64'(bus.err), 64'h0);
        step();
        sample();
        chk("to_c18_err", 64'(bus.err), 64'h1);
        chk("to_c18_dat", 64'(bus.dat_r), 64'h0);
        step();
        idle_bus();
        sample();
        chk("to_c19_err", 64'(bus.err), 64'h0);
`ifdef WB_DECODE_MUX_STATS_EN
        chk("to_errcnt", 64'(err_count), 64'h2);
        chk("to_erradr", 64'(last_err_adr), 64'h00001000);
        chk("to_cause", 64'(last_err_cause), 64'h1);
`endif
        step();

        // Ack in the very cycle the watchdog expires wins
        req(32'h00001000, 1'b0, CTI_CLASSIC);
        sample();
        repeat (17) step();
        force_ack = 3'b010;
        sample();
        chk("race_c17_ack", 64'(bus.ack), 64'h1);
        chk("race_c17_err", 64'(bus.err), 64'h0);
        chk("race_c17_dat", 64'(bus.dat_r), 64'h22222222);
        step();
        force_ack = '0;
        sample();
        chk("race_c18_err", 64'(bus.err), 64'h0);
        chk("race_c18_stb", 64'(wbs_stb_o), 64'h2);
        step();
        idle_bus();
        sample();
        chk("race_c19_err", 64'(bus.err), 64'h0);
`ifdef WB_DECODE_MUX_STATS_EN
        chk("race_errcnt", 64'(err_count), 64'h2);
`endif
        step();

        // Incrementing burst crossing into slave2's window stays on slave1
        zw_en = 3'b111;
        req(32'h0000103C, 1'b0, CTI_INCR);
        sample();
        chk("bst_c0_stb", 64'(wbs_stb_o), 64'h0);
        for (int b = 0; b < 8; b++) begin
            step();
            if (b > 0) begin
                bus.adr = 32'h0000103C + 32'(4 * b);
                bus.cti = (b == 7) ? CTI_EOB : CTI_INCR;
            end
            sample();
            chk($sformatf("bst_b%0d_stb", b), 64'(wbs_stb_o), 64'h2);
            chk($sformatf("bst_b%0d_dat", b), {31'h0, bus.ack, bus.dat_r}, {31'h0, 1'b1, 32'h22222222});
        end
        step();
        idle_bus();
        sample();
        chk("bst_end_stb", 64'(wbs_stb_o), 64'h0);
        step();

        // Reset mid-ACTIVE, then a normal access with a back-to-back beat
        zw_en = 3'b000;
        req(32'h00001000, 1'b0, CTI_CLASSIC);
        sample();
        step();
        sample();
        chk("rstm_c1_stb", 64'(wbs_stb_o), 64'h2);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle_bus();
        force_ack = 3'b111;
        sample();
        chk("rstm_cyc", 64'(wbs_cyc_o), 64'h0);
        chk("rstm_ack", 64'(bus.ack), 64'h0);
        chk("rstm_err", 64'(bus.err), 64'h0);
`ifdef WB_DECODE_MUX_STATS_EN
        chk("rstm_errcnt", 64'(err_count), 64'h0);
`endif
        step();
        force_ack = '0;
        zw_en = 3'b001;
        req(32'h00000010, 1'b0, CTI_CLASSIC);
        sample();
        step();
        sample();
        chk("post_stb", 64'(wbs_stb_o), 64'h1);
        chk("post_ack", 64'(bus.ack), 64'h1);
        chk("post_dat", 64'(bus.dat_r), 64'h11111111);
        step();
        zw_en     = 3'b000;
        force_rty = 3'b001;
        bus.adr   = 32'h00001000;
        sample();
        chk("b2b_stb", 64'(wbs_stb_o), 64'h1);
        chk("b2b_rty", 64'(bus.rty), 64'h1);
        step();
        force_rty = '0;
        idle_bus();
        sample();
        chk("b2b_end_cyc", 64'(wbs_cyc_o), 64'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
